fft_r2_inplace_sequencer: RTL and testbench

Control and address generator for one shared radix-2 butterfly doing an in-place N-point DIF FFT over a dual-port sample RAM.
- Per stage, issues N/2 butterfly operations: read address pair plus twiddle index.
- Replays each address pair on the write side after the datapath latency.
- Drains the pipeline between stages so no stage reads data before the previous stage has written it.
- Sits between the top-level FFT control, the sample RAM, the twiddle ROM and the registered butterfly pipeline.

---
 rtl/fft_r2_inplace_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fft_r2_inplace_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_r2_inplace_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIF FFT on one shared butterfly.
// Optional FFT_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter port (cycle_cnt).
module fft_r2_inplace_sequencer #(
  parameter int unsigned LOG2_N     = 4,
  parameter int unsigned BF_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(LOG2_N)-1:0]  stage,
  output logic                       rd_en,
  output logic [LOG2_N-1:0]          rd_addr_a,
  output logic [LOG2_N-1:0]          rd_addr_b,
  output logic [LOG2_N-2:0]          tw_addr,
  output logic                       wr_en,
`ifdef FFT_SEQ_CYCLE_CNT_EN
  output logic [15:0]                cycle_cnt,
`endif
  output logic [LOG2_N-1:0]          wr_addr_a,
  output logic [LOG2_N-1:0]          wr_addr_b
);

  localparam int unsigned AW   = LOG2_N;
  localparam int unsigned TW   = LOG2_N - 1;
  localparam int unsigned SW   = $clog2(LOG2_N);
  localparam int unsigned DW   = 4;
  localparam int unsigned HALF = 2 ** (LOG2_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [TW-1:0]   k_q, k_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_a_q, rd_a_d;
  logic [AW-1:0]   rd_b_q, rd_b_d;
  logic [TW-1:0]   tw_q, tw_d;

  logic [BF_LATENCY-1:0] wen_pipe_q;
  logic [AW-1:0]         wa_pipe_q [BF_LATENCY];
  logic [AW-1:0]         wb_pipe_q [BF_LATENCY];

  logic [AW-1:0]   p_w, kw_w, mask_w, addr_a_w, addr_b_w;
  logic [TW-1:0]   tw_w;

  // Insert a zero at bit p of k to form the upper leg; lower leg sets that bit.
  always_comb begin : addr_gen
    p_w      = AW'(LOG2_N - 1) - AW'(s_q);
    kw_w     = AW'(k_q);
    mask_w   = (AW'(1) << p_w) - AW'(1);
    addr_a_w = ((kw_w >> p_w) << (p_w + AW'(1))) | (kw_w & mask_w);
    addr_b_w = addr_a_w | (AW'(1) << p_w);
    tw_w     = TW'((kw_w & mask_w) << s_q);
  end

  always_comb begin : fsm_next
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == TW'(HALF - 1)) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(BF_LATENCY - 1)) begin
          if (s_q == SW'(LOG2_N - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            s_d     = s_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_en_d = (state_q == S_RUN);
    rd_a_d  = rd_en_d ? addr_a_w : '0;
    rd_b_d  = rd_en_d ? addr_b_w : '0;
    tw_d    = rd_en_d ? tw_w : '0;
    busy_d  = (state_q == S_RUN) || (state_q == S_DRAIN);
    done_d  = (state_q == S_DONE);
    stage_d = (state_q == S_IDLE) ? '0 : s_q;
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_regs
    if (rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stage_q <= stage_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
    end
  end

  // Write side replays the read pair after the butterfly latency.
  always_ff @(posedge clk or posedge rst) begin : wr_pipe
    if (rst) begin
      wen_pipe_q <= '0;
      for (int unsigned i = 0; i < BF_LATENCY; i++) begin
        wa_pipe_q[i] <= '0;
        wb_pipe_q[i] <= '0;
      end
    end else begin
      wen_pipe_q[0] <= rd_en_q;
      wa_pipe_q[0]  <= rd_a_q;
      wb_pipe_q[0]  <= rd_b_q;
      for (int unsigned i = 1; i < BF_LATENCY; i++) begin
        wen_pipe_q[i] <= wen_pipe_q[i-1];
        wa_pipe_q[i]  <= wa_pipe_q[i-1];
        wb_pipe_q[i]  <= wb_pipe_q[i-1];
      end
    end
  end

`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin : cnt_next
    cnt_d = cnt_q;
    if ((state_q == S_IDLE) && start) begin
      cnt_d = '0;
    end else if (((state_q == S_RUN) || (state_q == S_DRAIN)) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : cnt_reg
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;
  assign wr_en     = wen_pipe_q[BF_LATENCY-1];
  assign wr_addr_a = wa_pipe_q[BF_LATENCY-1];
  assign wr_addr_b = wb_pipe_q[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_r2_inplace_sequencer.sv
// Directed bench for fft_r2_inplace_sequencer: N=16/latency 2 and N=4/latency 1 instances.
module tb_fft_r2_inplace_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic       busy0, done0, rd_en0, wr_en0;
  logic [1:0] stage0;
  logic [3:0] ra0, rb0, wa0, wb0;
  logic [2:0] tw0;

  logic       busy1, done1, rd_en1, wr_en1;
  logic [0:0] stage1, tw1;
  logic [1:0] ra1, rb1, wa1, wb1;

`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [15:0] cc0, cc1;
`endif

  int checks = 0;
  int errors = 0;

  // Stage-major read table for N=16: upper leg, lower leg, twiddle.
  int ta [32] = '{0,1,2,3,4,5,6,7,  0,1,2,3,8,9,10,11,  0,1,4,5,8,9,12,13,  0,2,4,6,8,10,12,14};
  int tb [32] = '{8,9,10,11,12,13,14,15,  4,5,6,7,12,13,14,15,  2,3,6,7,10,11,14,15,  1,3,5,7,9,11,13,15};
  int tt [32] = '{0,1,2,3,4,5,6,7,  0,2,4,6,0,2,4,6,  0,4,0,4,0,4,0,4,  0,0,0,0,0,0,0,0};

  // Expected N=4, latency-1 waveform, indexed by cycle after the start edge.
  int e1_rd [11] = '{0,1,1,0,1,1,0,0,0,0,0};
  int e1_a  [11] = '{0,0,1,0,0,2,0,0,0,0,0};
  int e1_b  [11] = '{0,2,3,0,1,3,0,0,0,0,0};
  int e1_t  [11] = '{0,0,1,0,0,0,0,0,0,0,0};
  int e1_wr [11] = '{0,0,1,1,0,1,1,0,0,0,0};
  int e1_wa [11] = '{0,0,0,1,0,0,2,0,0,0,0};
  int e1_wb [11] = '{0,0,2,3,0,1,3,0,0,0,0};

  fft_r2_inplace_sequencer #(.LOG2_N(4), .BF_LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .busy(busy0), .done(done0), .stage(stage0),
    .rd_en(rd_en0), .rd_addr_a(ra0), .rd_addr_b(rb0), .tw_addr(tw0),
    .wr_en(wr_en0),
`ifdef FFT_SEQ_CYCLE_CNT_EN
    .cycle_cnt(cc0),
`endif
    .wr_addr_a(wa0), .wr_addr_b(wb0)
  );

  fft_r2_inplace_sequencer #(.LOG2_N(2), .BF_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy1), .done(done1), .stage(stage1),
    .rd_en(rd_en1), .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1),
    .wr_en(wr_en1),
`ifdef FFT_SEQ_CYCLE_CNT_EN
    .cycle_cnt(cc1),
`endif
    .wr_addr_a(wa1), .wr_addr_b(wb1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Table index of the read issued in cycle rel of a transform, or -1 if none.
  function automatic int ridx(input int rel);
    int off;
    if (rel < 1 || rel > 40) return -1;
    off = (rel - 1) % 10;
    if (off >= 8) return -1;
    return ((rel - 1) / 10) * 8 + off;
  endfunction

  // Compare every u0 output against the expected waveform at cycle rel.
  task automatic chk_t(input int rel);
    int j, w, st;
    j  = ridx(rel);
    w  = ridx(rel - 2);
    st = (rel >= 1 && rel <= 40) ? (rel - 1) / 10 : ((rel == 41) ? 3 : 0);
    chk($sformatf("rd_en@%0d", rel), 32'(rd_en0), (j >= 0) ? 1 : 0);
    chk($sformatf("rd_a@%0d", rel), 32'(ra0), (j >= 0) ? ta[j] : 0);
    chk($sformatf("rd_b@%0d", rel), 32'(rb0), (j >= 0) ? tb[j] : 0);
    chk($sformatf("tw@%0d", rel), 32'(tw0), (j >= 0) ? tt[j] : 0);
    chk($sformatf("wr_en@%0d", rel), 32'(wr_en0), (w >= 0) ? 1 : 0);
    chk($sformatf("wr_a@%0d", rel), 32'(wa0), (w >= 0) ? ta[w] : 0);
    chk($sformatf("wr_b@%0d", rel), 32'(wb0), (w >= 0) ? tb[w] : 0);
    chk($sformatf("busy@%0d", rel), 32'(busy0), (rel >= 1 && rel <= 40) ? 1 : 0);
    chk($sformatf("done@%0d", rel), 32'(done0), (rel == 41) ? 1 : 0);
    chk($sformatf("stage@%0d", rel), 32'(stage0), st);
  endtask

  // One full N=16 transform from a single start pulse; optionally pokes start mid-run.
  task automatic run_t1(input bit poke20);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 0; c <= 45; c++) begin
      chk_t(c);
`ifdef FFT_SEQ_CYCLE_CNT_EN
      if (c == 0)  chk("cnt_start", 32'(cc0), 0);
      if (c == 20) chk("cnt_mid", 32'(cc0), 20);
      if (c == 41) chk("cnt_done", 32'(cc0), 40);
      if (c == 45) chk("cnt_hold", 32'(cc0), 40);
`endif
      start0 = (poke20 && c == 20);
      step();
    end
    start0 = 1'b0;
  endtask

  initial begin
    int nrd, nwr;

    // Reset state
    #2;
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_rd_en0", 32'(rd_en0), 0);
    chk("rst_wr_en0", 32'(wr_en0), 0);
    chk("rst_done1", 32'(done1), 0);
    chk("rst_wr_en1", 32'(wr_en1), 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Single transform, with an ignored start pulse mid-run
    run_t1(1'b1);

    // Continuous start: back-to-back transforms with one idle cycle between
    start0 = 1'b1;
    step();
    for (int c = 0; c <= 83; c++) begin
      chk_t((c < 42) ? c : c - 42);
      if (c == 83) start0 = 1'b0;
      step();
    end
    for (int c = 0; c < 4; c++) begin
      chk("idle_after_b2b_busy", 32'(busy0), 0);
      chk("idle_after_b2b_rd", 32'(rd_en0), 0);
      step();
    end

    // Asynchronous reset in the middle of stage 1
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      chk_t(c);
      if (c < 15) step();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_en", 32'(rd_en0), 0);
    chk("arst_busy", 32'(busy0), 0);
    chk("arst_stage", 32'(stage0), 0);
    chk("arst_rd_a", 32'(ra0), 0);
    chk("arst_rd_b", 32'(rb0), 0);
    chk("arst_tw", 32'(tw0), 0);
    chk("arst_wr_en", 32'(wr_en0), 0);
    chk("arst_wr_b", 32'(wb0), 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("post_rst_wr_en", 32'(wr_en0), 0);
      chk("post_rst_busy", 32'(busy0), 0);
      step();
    end
    run_t1(1'b0);

    // Small configuration: N=4, single-cycle latency
    nrd = 0;
    nwr = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("s_rd_en@%0d", c), 32'(rd_en1), e1_rd[c]);
      chk($sformatf("s_rd_a@%0d", c), 32'(ra1), e1_a[c]);
      chk($sformatf("s_rd_b@%0d", c), 32'(rb1), e1_b[c]);
      chk($sformatf("s_tw@%0d", c), 32'(tw1), e1_t[c]);
      chk($sformatf("s_wr_en@%0d", c), 32'(wr_en1), e1_wr[c]);
      chk($sformatf("s_wr_a@%0d", c), 32'(wa1), e1_wa[c]);
      chk($sformatf("s_wr_b@%0d", c), 32'(wb1), e1_wb[c]);
      chk($sformatf("s_done@%0d", c), 32'(done1), (c == 7) ? 1 : 0);
      chk($sformatf("s_busy@%0d", c), 32'(busy1), (c >= 1 && c <= 6) ? 1 : 0);
      chk($sformatf("s_stage@%0d", c), 32'(stage1), (c >= 4 && c <= 7) ? 1 : 0);
`ifdef FFT_SEQ_CYCLE_CNT_EN
      if (c == 7) chk("s_cnt_done", 32'(cc1), 6);
`endif
      if (rd_en1 === 1'b1) nrd++;
      if (wr_en1 === 1'b1) nwr++;
      step();
    end
    chk("s_rd_count", 32'(nrd), 4);
    chk("s_wr_count", 32'(nwr), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
